// File: rtl/ddr_rd_responder_pkg.sv
// rtl/ddr_rd_responder_pkg.sv - shared widths and types for the DDR read responder
package ddr_rd_responder_pkg;

    localparam int DDR_W      = 512;
    localparam int DDR_ADDR_W = 30;
    localparam int BURST_W    = 8;

    typedef enum logic [1:0] {
        RSP_IDLE,
        RSP_WAIT,
        RSP_BURST
    } rsp_state_t;

    typedef struct packed {
        logic [DDR_ADDR_W-1:0] addr;
        logic [BURST_W-1:0]    size;
    } ddr_req_t;

endpackage

// File: rtl/ddr_rd_responder_req_fifo.sv
// rtl/ddr_rd_responder_req_fifo.sv - synchronous request FIFO of ddr_req_t with full/empty
module ddr_req_fifo
    import ddr_rd_responder_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     push,
    input  ddr_req_t din,
    input  logic     pop,
    output ddr_req_t dout,
    output logic     full,
    output logic     empty
);

    localparam int PW = $clog2(DEPTH);

    ddr_req_t       mem [DEPTH];
    logic [PW:0]    wr_ptr;
    logic [PW:0]    rd_ptr;
    logic           do_push;
    logic           do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr[PW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[PW-1:0]] <= din;
    end

endmodule

// File: rtl/ddr_rd_responder.sv
// rtl/ddr_rd_responder.sv - DDR read-channel responder backed by an inferred dual-port RAM
module ddr_rd_responder
    import ddr_rd_responder_pkg::*;
#(
    parameter int MEM_DEPTH = 4096,
    parameter int REQ_DEPTH = 4,
    parameter int RESP_LAT  = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [DDR_ADDR_W-1:0]        ddr_in_addr,
    input  logic [BURST_W-1:0]           ddr_in_size,
    input  logic                         ddr_in_addr_valid,
    output logic                         ddr_in_addr_ready,
    output logic [DDR_W-1:0]             ddr_in_data,
    output logic                         ddr_in_valid,
    input  logic                         ddr_in_ready,
    input  logic                         pre_wr_en,
    input  logic [$clog2(MEM_DEPTH)-1:0] pre_wr_addr,
    input  logic [DDR_W-1:0]             pre_wr_data,
    output logic                         busy
);

    localparam int AW       = $clog2(MEM_DEPTH);
    localparam int ADDR_LSB = $clog2(DDR_W / 8);

    ddr_req_t         req_in;
    ddr_req_t         req_head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_pop;
    logic             ready_q;

    rsp_state_t       state, state_nxt;
    logic [AW-1:0]    ptr, ptr_nxt;
    logic [BURST_W-1:0] beats, beats_nxt;
    logic [3:0]       lat_cnt, lat_nxt;

    logic [DDR_W-1:0] mem [MEM_DEPTH];
    logic [DDR_W-1:0] mem_q;
    logic             rd_en;
    logic             rd_pend;

    logic [DDR_W-1:0] skid [2];
    logic             skid_wr;
    logic             skid_rd;
    logic [1:0]       skid_cnt;
    logic             skid_push;
    logic             skid_pop;
    logic             pop_out;
    logic [2:0]       pend_after;
    logic             can_issue;

    // Ready is held low through reset and released one clock later.
    assign ddr_in_addr_ready = ready_q && !fifo_full;
    assign req_in.addr       = ddr_in_addr;
    assign req_in.size       = ddr_in_size;

    ddr_req_fifo #(
        .DEPTH (REQ_DEPTH)
    ) u_req_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (ddr_in_addr_valid && ddr_in_addr_ready),
        .din   (req_in),
        .pop   (fifo_pop),
        .dout  (req_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // The registered RAM output acts as a third holding slot ahead of the skid pair.
    assign ddr_in_valid = (skid_cnt != 2'd0) || rd_pend;
    assign ddr_in_data  = (skid_cnt != 2'd0) ? skid[skid_rd] : (rd_pend ? mem_q : '0);
    assign pop_out      = ddr_in_valid && ddr_in_ready;
    assign skid_pop     = (skid_cnt != 2'd0) && pop_out;
    assign skid_push    = rd_pend && !((skid_cnt == 2'd0) && pop_out);
    assign pend_after   = {1'b0, skid_cnt} + {2'b0, rd_pend} - {2'b0, pop_out};
    assign can_issue    = (pend_after <= 3'd1);

    assign busy = !fifo_empty || (state != RSP_IDLE) || ddr_in_valid;

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        beats_nxt = beats;
        lat_nxt   = lat_cnt;
        fifo_pop  = 1'b0;
        rd_en     = 1'b0;
        unique case (state)
            RSP_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    ptr_nxt   = AW'(req_head.addr >> ADDR_LSB);
                    beats_nxt = req_head.size;
                    if (req_head.size != '0) begin
                        if (RESP_LAT == 0) begin
                            state_nxt = RSP_BURST;
                        end else begin
                            state_nxt = RSP_WAIT;
                            lat_nxt   = 4'(RESP_LAT);
                        end
                    end
                end
            end
            RSP_WAIT: begin
                lat_nxt = lat_cnt - 4'd1;
                if (lat_cnt <= 4'd1) state_nxt = RSP_BURST;
            end
            RSP_BURST: begin
                if (beats != '0) begin
                    if (can_issue) begin
                        rd_en     = 1'b1;
                        ptr_nxt   = ptr + 1'b1;
                        beats_nxt = beats - 1'b1;
                    end
                end else if (pop_out && (pend_after == 3'd0)) begin
                    state_nxt = RSP_IDLE;
                end
            end
            default: state_nxt = RSP_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RSP_IDLE;
            ptr      <= '0;
            beats    <= '0;
            lat_cnt  <= '0;
            ready_q  <= 1'b0;
            rd_pend  <= 1'b0;
            skid_cnt <= '0;
            skid_wr  <= 1'b0;
            skid_rd  <= 1'b0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            beats    <= beats_nxt;
            lat_cnt  <= lat_nxt;
            ready_q  <= 1'b1;
            rd_pend  <= rd_en;
            skid_cnt <= skid_cnt + {1'b0, skid_push} - {1'b0, skid_pop};
            if (skid_push) skid_wr <= ~skid_wr;
            if (skid_pop)  skid_rd <= ~skid_rd;
        end
    end

    // Separate write and read processes give read-first behaviour on a shared index.
    always_ff @(posedge clk) begin
        if (pre_wr_en) mem[pre_wr_addr] <= pre_wr_data;
    end

    always_ff @(posedge clk) begin
        if (rd_en) mem_q <= mem[ptr];
    end

    always_ff @(posedge clk) begin
        if (skid_push) skid[skid_wr] <= mem_q;
    end

endmodule

// File: tb/tb_ddr_rd_responder.sv
// tb/tb_ddr_rd_responder.sv - self-checking bench for ddr_rd_responder
module tb_ddr_rd_responder;
    import ddr_rd_responder_pkg::*;

    localparam int MEM_DEPTH = 4096;
    localparam int AW        = 12;
    localparam int RESP_LAT  = 4;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [DDR_ADDR_W-1:0] ddr_in_addr;
    logic [BURST_W-1:0]    ddr_in_size;
    logic                  ddr_in_addr_valid;
    logic                  ddr_in_addr_ready;
    logic [DDR_W-1:0]      ddr_in_data;
    logic                  ddr_in_valid;
    logic                  ddr_in_ready;
    logic                  pre_wr_en;
    logic [AW-1:0]         pre_wr_addr;
    logic [DDR_W-1:0]      pre_wr_data;
    logic                  busy;

    always #5 clk = ~clk;

    ddr_rd_responder #(
        .MEM_DEPTH (MEM_DEPTH),
        .REQ_DEPTH (4),
        .RESP_LAT  (RESP_LAT)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .ddr_in_addr       (ddr_in_addr),
        .ddr_in_size       (ddr_in_size),
        .ddr_in_addr_valid (ddr_in_addr_valid),
        .ddr_in_addr_ready (ddr_in_addr_ready),
        .ddr_in_data       (ddr_in_data),
        .ddr_in_valid      (ddr_in_valid),
        .ddr_in_ready      (ddr_in_ready),
        .pre_wr_en         (pre_wr_en),
        .pre_wr_addr       (pre_wr_addr),
        .pre_wr_data       (pre_wr_data),
        .busy              (busy)
    );

    logic [DDR_W-1:0] model_mem [MEM_DEPTH];
    logic [DDR_W-1:0] exp_q [$];
    int               n_cmp = 0;
    int               n_bad = 0;
    int               n_beats = 0;
    logic             prev_hold = 1'b0;
    logic [DDR_W-1:0] prev_data = '0;
    logic             acc_flag;
    logic             rand_ready = 1'b0;

    task automatic chk(input string tag, input logic [DDR_W-1:0] obs, input logic [DDR_W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: check outputs against the model, record handshakes, advance to the next negedge.
    task automatic cycle();
        logic [DDR_W-1:0] e;
        logic             no_exp;
        logic [AW-1:0]    w;
        if (rand_ready) ddr_in_ready = ($urandom_range(0, 3) != 0);
        #1;
        acc_flag = 1'b0;
        if (!rst) begin
            if (prev_hold) begin
                chk("hold_valid", DDR_W'(ddr_in_valid), DDR_W'(1));
                chk("hold_data", ddr_in_data, prev_data);
            end
            if (ddr_in_valid && ddr_in_ready) begin
                no_exp = (exp_q.size() == 0);
                chk("no_extra_beat", DDR_W'(no_exp), DDR_W'(0));
                if (!no_exp) begin
                    e = exp_q.pop_front();
                    chk("beat_data", ddr_in_data, e);
                end
                n_beats++;
            end
            if (ddr_in_addr_valid && ddr_in_addr_ready) begin
                acc_flag = 1'b1;
                w = AW'(ddr_in_addr / (DDR_W / 8));
                for (int k = 0; k < int'(ddr_in_size); k++)
                    exp_q.push_back(model_mem[AW'(int'(w) + k)]);
            end
            prev_hold = ddr_in_valid && !ddr_in_ready;
            prev_data = ddr_in_data;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic preload(input int idx, input logic [DDR_W-1:0] d);
        pre_wr_en   = 1'b1;
        pre_wr_addr = AW'(idx);
        pre_wr_data = d;
        model_mem[idx] = d;
        cycle();
        pre_wr_en = 1'b0;
    endtask

    task automatic send_req(input logic [DDR_ADDR_W-1:0] a, input logic [BURST_W-1:0] s);
        int k;
        logic hs;
        ddr_in_addr       = a;
        ddr_in_size       = s;
        ddr_in_addr_valid = 1'b1;
        k  = 0;
        hs = 1'b0;
        while (!hs && k < 200) begin
            cycle();
            hs = acc_flag;
            k++;
        end
        ddr_in_addr_valid = 1'b0;
        chk("req_accepted", DDR_W'(hs), DDR_W'(1));
    endtask

    task automatic drain();
        int k;
        rand_ready   = 1'b0;
        ddr_in_ready = 1'b1;
        k = 0;
        while ((exp_q.size() != 0 || busy) && k < 1000) begin
            cycle();
            k++;
        end
        chk("drain_empty", DDR_W'(exp_q.size()), DDR_W'(0));
        chk("drain_idle", DDR_W'(busy), DDR_W'(0));
    endtask

    task automatic wait_valid(output int k);
        k = 0;
        while (!ddr_in_valid && k < 40) begin
            cycle();
            k++;
        end
    endtask

    initial begin
        int k;
        int b0;
        int ready_pat [6];
        int w;
        ready_pat = '{1, 0, 0, 1, 0, 1};

        rst = 1'b1;
        ddr_in_addr = '0; ddr_in_size = '0; ddr_in_addr_valid = 1'b0; ddr_in_ready = 1'b0;
        pre_wr_en = 1'b0; pre_wr_addr = '0; pre_wr_data = '0;
        @(negedge clk); @(negedge clk); #1;
        chk("rst_addr_ready", DDR_W'(ddr_in_addr_ready), DDR_W'(0));
        chk("rst_valid", DDR_W'(ddr_in_valid), DDR_W'(0));
        chk("rst_data", ddr_in_data, '0);
        chk("rst_busy", DDR_W'(busy), DDR_W'(0));
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("post_rst_ready", DDR_W'(ddr_in_addr_ready), DDR_W'(1));

        for (int i = 0; i < 32; i++) preload(i, DDR_W'(i));
        for (int i = 4064; i < 4096; i++) preload(i, {16{$urandom()}});

        // Latency, back-to-back beats, busy release.
        ddr_in_ready = 1'b1;
        ddr_in_addr = '0; ddr_in_size = 8'd8; ddr_in_addr_valid = 1'b1;
        chk("t1_addr_ready", DDR_W'(ddr_in_addr_ready), DDR_W'(1));
        cycle();
        ddr_in_addr_valid = 1'b0;
        wait_valid(k);
        chk("t1_first_beat_lat", DDR_W'(k), DDR_W'(RESP_LAT + 2));
        for (int i = 0; i < 8; i++) begin
            chk("t1_b2b_valid", DDR_W'(ddr_in_valid), DDR_W'(1));
            cycle();
        end
        chk("t1_busy_fall", DDR_W'(busy), DDR_W'(0));
        chk("t1_queue_empty", DDR_W'(exp_q.size()), DDR_W'(0));

        // Backpressure with a fixed ready pattern.
        b0 = n_beats;
        send_req('0, 8'd8);
        k = 0;
        while (n_beats - b0 < 8 && k < 300) begin
            ddr_in_ready = ready_pat[k % 6] != 0;
            cycle();
            k++;
        end
        drain();
        chk("t2_beat_count", DDR_W'(n_beats - b0), DDR_W'(8));

        // FIFO fill with the output stalled.
        b0 = n_beats;
        ddr_in_ready = 1'b0;
        for (int i = 0; i < 5; i++) send_req(DDR_ADDR_W'(i * 2 * 64), 8'd2);
        for (int i = 0; i < 4; i++) cycle();
        chk("t3_full_ready_low", DDR_W'(ddr_in_addr_ready), DDR_W'(0));
        chk("t3_busy", DDR_W'(busy), DDR_W'(1));
        drain();
        chk("t3_beat_count", DDR_W'(n_beats - b0), DDR_W'(10));

        // Wrap at end of memory with unaligned byte address.
        b0 = n_beats;
        send_req(DDR_ADDR_W'(4094 * 64 + 13), 8'd4);
        drain();
        chk("t4_beat_count", DDR_W'(n_beats - b0), DDR_W'(4));

        // Empty request followed immediately by a one-beat request.
        b0 = n_beats;
        ddr_in_addr = '0; ddr_in_size = '0; ddr_in_addr_valid = 1'b1;
        chk("t5_ready0", DDR_W'(ddr_in_addr_ready), DDR_W'(1));
        cycle();
        ddr_in_addr = DDR_ADDR_W'(64); ddr_in_size = 8'd1;
        chk("t5_ready1", DDR_W'(ddr_in_addr_ready), DDR_W'(1));
        cycle();
        ddr_in_addr_valid = 1'b0;
        wait_valid(k);
        chk("t5_lat_no_wait", DDR_W'(k), DDR_W'(RESP_LAT + 2));
        chk("t5_data", ddr_in_data, DDR_W'(1));
        drain();
        chk("t5_beat_count", DDR_W'(n_beats - b0), DDR_W'(1));

        // Reset asserted while beat 3 is on the bus.
        send_req('0, 8'd8);
        wait_valid(k);
        cycle(); cycle();
        rst = 1'b1;
        #1;
        chk("t6_valid_async", DDR_W'(ddr_in_valid), DDR_W'(0));
        chk("t6_busy_async", DDR_W'(busy), DDR_W'(0));
        exp_q.delete();
        prev_hold = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("t6_ready_after", DDR_W'(ddr_in_addr_ready), DDR_W'(1));
        chk("t6_busy_after", DDR_W'(busy), DDR_W'(0));
        b0 = n_beats;
        send_req(DDR_ADDR_W'(5 * 64), 8'd1);
        drain();
        chk("t6_fresh_read", DDR_W'(n_beats - b0), DDR_W'(1));

        // Randomized traffic with random backpressure.
        b0 = n_beats;
        rand_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            w = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 20)) : int'($urandom_range(4088, 4095));
            send_req(DDR_ADDR_W'(w * 64 + int'($urandom_range(0, 63))), BURST_W'($urandom_range(0, 8)));
            for (int g = 0; g < int'($urandom_range(0, 3)); g++) cycle();
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
